wb_logic_slave: RTL
===================

# wb_logic_slave

Wishbone classic (B3, non-pipelined) slave on the conbus slave side, the responder counterpart to the bus masters driving it. It holds two operand registers C and D, two read-only result registers A = C & D and B = C | D, and a small scratch bank. It answers every request with a registered single-cycle ack after a configurable number of wait states. It serves as the bring-up target for conbus routing and the FPU register path.

## Interface
- ADDR_W, 4, word-address width of adr_i
- NSCRATCH, 4, number of 32-bit scratch registers at word addresses 4..3+NSCRATCH (1..12)
- WAIT_STATES, 0, extra cycles between request sample and ack (0..15)
- clk_i  in  1  single clock, all state on rising edge
- rst_n_i  in  1  synchronous active-low reset
- cyc_i  in  1  bus cycle valid
- stb_i  in  1  strobe
- we_i  in  1  1 = write
- adr_i  in  ADDR_W  word address
- sel_i  in  4  byte enables, writes only
- dat_i  in  32  write data
- dat_o  out  32  read data, valid only while ack_o=1
- ack_o  out  1  normal termination, one-cycle pulse
- err_o  out  1  error termination, see Configuration

## Operation
- Map: 0 C (rw), 1 D (rw), 2 A (ro), 3 B (ro), 4..3+NSCRATCH scratch (rw); all other addresses are out of range.
- FSM states:
  - IDLE: on cyc_i&stb_i, latch we/adr/sel/dat; go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: counts WAIT_STATES cycles, then goes to RESP.
  - RESP: drives ack_o or err_o for exactly one cycle, then returns to IDLE.
- Writes commit on the clock edge that ends RESP, per byte lane where sel_i=1.
- A/B update on that same edge from the post-write C/D values, so any later read sees consistent results.
- sel_i=0000 write: acked, no change.
- Write to A or B: dropped; termination per Configuration.
- Reads:
  - dat_o is registered and loaded on the edge entering RESP.
  - dat_o is 0 outside RESP.
  - Out-of-range reads return 0.
- Abort: cyc_i or stb_i low in WAIT returns the FSM to IDLE with no ack, no err and no write. A request present in IDLE is latched; stb_i is not re-checked in RESP.
- The FSM returns to IDLE after RESP regardless of stb_i. A still-asserted request is sampled again, giving one idle cycle between back-to-back transactions.

## Timing
- Reset values:
  - ack_o=0, err_o=0, dat_o=0, FSM=IDLE.
  - C=0, D=0, A=0, B=0, scratch=0.
- Latency: a request sampled at edge N produces ack_o high during cycle N+1+WAIT_STATES. Minimum transaction spacing is WAIT_STATES+2 cycles.
- ack_o and err_o are never high simultaneously and never high for two consecutive cycles.
- Reset asserted mid-transaction:
  - The next edge forces IDLE and deasserts ack_o/err_o.
  - A write in RESP at that edge is discarded; reset wins.

## Configuration
- WB_LOGIC_ERR_EN defined:
  - Out-of-range addresses, and writes to A/B, terminate with err_o instead of ack_o.
  - Same cycle timing as ack_o; no state change.
- Undefined:
  - The same cases terminate with ack_o; reads return 0, writes are dropped.
  - err_o is tied to 0.

## Structure
- Package wb_logic_pkg: address constants (ADR_C, ADR_D, ADR_A, ADR_B, ADR_SCR0) and the FSM state enum (IDLE, WAIT, RESP).
- One sub-module, wb_ack_timer:
  - Wait-state down-counter; load on request, done pulse when it expires.
  - Clear on abort or reset.

## Test plan
- Reset, then read addresses 0..3: each returns 0, with ack_o one cycle after request for WAIT_STATES=0.
- Write C=0x0000_00F0, D=0x0000_0FF0, then read A and B:
  - A=0x0000_00F0, B=0x0000_0FF0.
  - A/B read issued on the first legal cycle after the D ack already shows the new values.
- Byte-lane write, data 0xAABB_CCDD, sel 0100, to C=0: C reads 0x00BB_0000.
- WAIT_STATES=3: ack_o exactly 4 cycles after request. Dropping stb_i in cycle 2 gives no ack and no write, and C is unchanged.
- Write to adr 2 and read adr 15 (NSCRATCH=4):
  - With WB_LOGIC_ERR_EN: err_o pulses and A is unchanged.
  - Without it: ack_o pulses and the read returns 0.
- rst_n_i low during RESP of a write of 0x1234 to scratch 0: no ack is seen afterwards and scratch 0 reads 0.

Source files
------------

// File: rtl/wb_logic_pkg.sv
// Shared definitions for wb_logic_slave: register map, FSM states, byte-lane merge.
// Latency/backpressure: n/a (package only).
package wb_logic_pkg;

  localparam logic [31:0] ADR_C    = 32'd0;
  localparam logic [31:0] ADR_D    = 32'd1;
  localparam logic [31:0] ADR_A    = 32'd2;
  localparam logic [31:0] ADR_B    = 32'd3;
  localparam logic [31:0] ADR_SCR0 = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Wait-state down-counter: load on request, one-cycle done when the count expires.
// Latency: done is high in the WAIT_STATES-th cycle after load; clear/reset cancel it.
module wb_ack_timer
  import wb_logic_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load,
  input  logic clear,
  output logic done
);

  localparam logic [3:0] LOAD_VAL = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [3:0] cnt;
  logic       run;

  assign done = run && (cnt == 4'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear) begin
      run <= 1'b0;
      cnt <= 4'd0;
    end else if (load) begin
      run <= 1'b1;
      cnt <= LOAD_VAL;
    end else if (run) begin
      if (cnt == 4'd0) run <= 1'b0;
      else             cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/wb_logic_slave.sv
// Wishbone classic slave: C/D operands, A=C&D, B=C|D, scratch bank; WB_LOGIC_ERR_EN selects err_o.
// Latency: ack/err WAIT_STATES+1 cycles after request; no backpressure, request dropped in WAIT aborts.
module wb_logic_slave
  import wb_logic_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int NSCRATCH    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [3:0]        sel_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o
);

  state_t            state;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_adr;
  logic [3:0]        lat_sel;
  logic [31:0]       lat_dat;
  logic [31:0]       c_q, d_q, a_q, b_q;
  logic [31:0]       scr_q [NSCRATCH];

  logic req;
  logic tmr_done;
  assign req = cyc_i & stb_i;

  wb_ack_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .load   ((state == IDLE) && req),
    .clear  ((state == WAIT) && !req),
    .done   (tmr_done)
  );

  // With zero wait states the response is decoded from the live bus in the same edge it is latched.
  logic [31:0] dec_adr;
  logic        dec_we;
  assign dec_adr = (state == IDLE) ? 32'(adr_i) : 32'(lat_adr);
  assign dec_we  = (state == IDLE) ? we_i : lat_we;

  logic [31:0] rd_val;
  logic        in_range;
  always_comb begin
    rd_val   = '0;
    in_range = 1'b0;
    case (dec_adr)
      ADR_C: begin rd_val = c_q; in_range = 1'b1; end
      ADR_D: begin rd_val = d_q; in_range = 1'b1; end
      ADR_A: begin rd_val = a_q; in_range = 1'b1; end
      ADR_B: begin rd_val = b_q; in_range = 1'b1; end
      default: begin
        for (int i = 0; i < NSCRATCH; i++) begin
          if (dec_adr == ADR_SCR0 + 32'(i)) begin
            rd_val   = scr_q[i];
            in_range = 1'b1;
          end
        end
      end
    endcase
  end

  logic resp_bad;
`ifdef WB_LOGIC_ERR_EN
  logic err_q;
  assign resp_bad = !in_range || (dec_we && (dec_adr == ADR_A || dec_adr == ADR_B));
  assign err_o    = err_q;
`else
  assign resp_bad = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Writes land on the edge leaving RESP; A/B follow the post-write operands on that same edge.
  logic        commit;
  logic [31:0] c_nxt, d_nxt;
  assign commit = (state == RESP) && lat_we && in_range;
  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (commit && dec_adr == ADR_C) c_nxt = merge_bytes(c_q, lat_dat, lat_sel);
    if (commit && dec_adr == ADR_D) d_nxt = merge_bytes(d_q, lat_dat, lat_sel);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      ack_o   <= 1'b0;
      dat_o   <= '0;
      lat_we  <= 1'b0;
      lat_adr <= '0;
      lat_sel <= '0;
      lat_dat <= '0;
      c_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < NSCRATCH; i++) scr_q[i] <= '0;
`ifdef WB_LOGIC_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
      dat_o <= '0;
`ifdef WB_LOGIC_ERR_EN
      err_q <= 1'b0;
`endif
      c_q <= c_nxt;
      d_q <= d_nxt;
      a_q <= c_nxt & d_nxt;
      b_q <= c_nxt | d_nxt;
      for (int i = 0; i < NSCRATCH; i++) begin
        if (commit && dec_adr == ADR_SCR0 + 32'(i))
          scr_q[i] <= merge_bytes(scr_q[i], lat_dat, lat_sel);
      end

      case (state)
        IDLE: begin
          if (req) begin
            lat_we  <= we_i;
            lat_adr <= adr_i;
            lat_sel <= sel_i;
            lat_dat <= dat_i;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
            end else begin
              state <= RESP;
              ack_o <= !resp_bad;
              dat_o <= (dec_we || resp_bad) ? '0 : rd_val;
`ifdef WB_LOGIC_ERR_EN
              err_q <= resp_bad;
`endif
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (tmr_done) begin
            state <= RESP;
            ack_o <= !resp_bad;
            dat_o <= (dec_we || resp_bad) ? '0 : rd_val;
`ifdef WB_LOGIC_ERR_EN
            err_q <= resp_bad;
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
